noc_packetizer: RTL
===================

# noc_packetizer

Store-and-forward NoC output stage sitting directly downstream of the tile's header decoder/accelerator core. It accepts a 32-bit AXI-stream payload, buffers one complete packet (terminated by TLAST), and re-emits it onto the NoC as a header flit followed by the buffered payload. The header carries the destination and source tile IDs and the payload length.

## Interface
- XY_SZ, 4, bits per X or Y coordinate; a tile ID is XY_SZ*2 bits.
- OFFSET_SZ, 12, width of the header length field.
- DEPTH, 64, maximum payload words per packet; power of two, at most 2**OFFSET_SZ-1.

- clk_line  in  1  sole clock.
- clk_line_rst_high  in  1  reset; synchronous, active-high.
- HsrcId  in  XY_SZ*2  own tile ID, static.
- dst_id  in  XY_SZ*2  destination tile ID; sampled on the first accepted word of each packet.
- stream_in_TVALID/TDATA/TKEEP/TLAST  in  1/32/4/1  payload stream from the decoder.
- stream_in_TREADY  out  1  payload accept.
- stream_out_TVALID/TDATA/TKEEP/TLAST  out  1/32/4/1  NoC packet stream.
- stream_out_TREADY  in  1  NoC accept.
- pkt_overflow  out  1  one-cycle pulse when a packet exceeds DEPTH.

## Operation
- FSM states: FILL, DROP, HDR, DRAIN. Reset state: FILL.
- FILL:
  - stream_in_TREADY=1.
  - Each accepted word writes {TKEEP,TDATA} to buffer[wr_ptr] and increments wr_ptr.
  - On the first word, latch dst_id.
  - Accepted word with TLAST → HDR.
  - The DEPTH-th word accepted without TLAST → pulse pkt_overflow → DROP.
- DROP:
  - TREADY=1; words are discarded.
  - Accepted TLAST → HDR with length=DEPTH.
  - If the DEPTH-th word itself carries TLAST, go FILL→HDR with no overflow.
- HDR:
  - TVALID=1, TKEEP=4'hF, TLAST=0.
  - TDATA[31:24]=dst (latched), [23:16]=HsrcId, [15:12]=4'h0, [11:0]=length in words.
  - The field layout here is for XY_SZ=4, OFFSET_SZ=12; the package derives positions from the parameters.
  - Handshake → DRAIN with rd_ptr=0.
- DRAIN:
  - Present buffer[rd_ptr]. TLAST=1 when rd_ptr==length-1.
  - Handshake increments rd_ptr; handshake on the last word → FILL with wr_ptr=0.
- stream_in_TREADY=0 in HDR and DRAIN. Only one packet is in flight; no overlap of fill and drain.
- Minimum packet: a single word with TLAST gives length=1, i.e. header plus one payload flit.
- TKEEP is stored and returned per word unchanged.

## Timing
- Reset values:
  - stream_in_TREADY=1 (state FILL).
  - stream_out_TVALID=0, TDATA=0, TKEEP=0, TLAST=0.
  - pkt_overflow=0, pointers=0.
- Outputs are registered.
- Latency: TLAST accepted at cycle t → header TVALID at t+1. First payload word valid in the cycle after the header handshake. Payload words then stream back-to-back while TREADY=1.
- AXI rule: once stream_out_TVALID=1, TVALID/TDATA/TKEEP/TLAST hold until TREADY=1. TVALID does not depend combinationally on TREADY.
- Throughput: payload N words costs N fill cycles + (N+1) drain cycles minimum.
- Reset mid-packet (any state) → FILL next cycle, partial packet discarded, outputs at reset values.
- TVALID=0 in the input stream is legal at any point: no state change, no write.

## Structure
- Package noc_pkg:
  - typedef tile_id_t (logic [XY_SZ*2-1:0]).
  - Header field LSB/MSB constants (HDR_DST, HDR_SRC, HDR_RSVD, HDR_LEN).
  - FSM enum pkt_state_e {FILL, DROP, HDR, DRAIN}.
  - Function make_hdr(dst, src, len).
- Sub-module noc_pkt_buf: DEPTH×36 single-port-write / registered-read storage with wr_en/wr_addr/rd_addr. The FSM and pointers stay in noc_packetizer.

## Test plan
- 3-word packet 0xA0,0xA1,0xA2 (TLAST on 0xA2), dst_id=8'h21, HsrcId=8'h12, TREADY=1:
  - output header 0x21120003, then 0xA0, 0xA1, 0xA2; TLAST only on 0xA2.
  - Header appears the cycle after 0xA2 is accepted.
- Single word 0xDEADBEEF with TLAST → header length 1, then 0xDEADBEEF with TLAST=1.
- 70-word packet with DEPTH=64:
  - pkt_overflow pulses exactly once, on the cycle after word 64 is accepted.
  - Words 65–70 are accepted and dropped.
  - Header length=64; 64 payload words out, TLAST on word 64.
- Random TREADY backpressure (50%) during a 5-word packet: output data and TVALID stay stable while stalled; no word lost or duplicated; stream_in_TREADY=0 until the last word drains.
- Reset asserted mid-DRAIN after 2 of 4 words: next cycle TVALID=0 and TREADY=1. A following 2-word packet emits a header with length 2 and the correct data.
- Exactly 64 words with TLAST on word 64: no overflow pulse, header length=64.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types, header field positions and helpers for the NoC packetizer.
package noc_pkg;

  localparam int XY_SZ     = 4;
  localparam int OFFSET_SZ = 12;
  localparam int DEF_DEPTH = 64;
  localparam int DATA_W    = 32;
  localparam int KEEP_W    = 4;

  typedef logic [XY_SZ*2-1:0]   tile_id_t;
  typedef logic [OFFSET_SZ-1:0] pkt_len_t;

  // Header flit layout, packed from the MSB down: dst, src, reserved, length.
  localparam int HDR_DST_MSB  = DATA_W - 1;
  localparam int HDR_DST_LSB  = DATA_W - 2*XY_SZ;
  localparam int HDR_SRC_MSB  = HDR_DST_LSB - 1;
  localparam int HDR_SRC_LSB  = HDR_DST_LSB - 2*XY_SZ;
  localparam int HDR_RSVD_MSB = HDR_SRC_LSB - 1;
  localparam int HDR_RSVD_LSB = OFFSET_SZ;
  localparam int HDR_LEN_MSB  = OFFSET_SZ - 1;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DROP  = 2'd1,
    HDR   = 2'd2,
    DRAIN = 2'd3
  } pkt_state_e;

  function automatic logic [DATA_W-1:0] make_hdr(tile_id_t dst, tile_id_t src, pkt_len_t len);
    logic [DATA_W-1:0] h;
    h = '0;
    h[HDR_DST_MSB:HDR_DST_LSB] = dst;
    h[HDR_SRC_MSB:HDR_SRC_LSB] = src;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return h;
  endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// AXI-stream style bundle used for both the payload input and the NoC output.
interface noc_packetizer_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/noc_pkt_buf.sv
// Packet payload store: one write port, one registered read port.
module noc_pkt_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the accepted word and register the addressed read word every cycle.
  // NOTE: the array has no reset; every location is written before it is read, so a reset would only cost area.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/noc_packetizer.sv
// Store-and-forward packetizer: buffers one payload packet, then emits header + payload.
module noc_packetizer
  import noc_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_line,
  input  logic             clk_line_rst_high,
  input  tile_id_t         HsrcId,
  input  tile_id_t         dst_id,
  noc_packetizer_if.slave  stream_in,
  noc_packetizer_if.master stream_out,
  output logic             pkt_overflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_FILL  = FILL;
  localparam logic [1:0] ST_DROP  = DROP;
  localparam logic [1:0] ST_HDR   = HDR;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     rd_addr;
  pkt_len_t          len_q;
  pkt_len_t          fill_len;
  tile_id_t          dst_q;
  tile_id_t          dst_sel;
  logic [DATA_W-1:0] hdr_q;
  logic [35:0]       rd_data;
  logic              in_hs;
  logic              out_hs;
  logic              wr_en;
  logic              last_word;

  assign in_hs     = stream_in.tvalid && stream_in.tready;
  assign out_hs    = stream_out.tvalid && stream_out.tready;
  assign wr_en     = (state == ST_FILL) && in_hs;
  assign fill_len  = pkt_len_t'(wr_ptr) + pkt_len_t'(1);
  assign dst_sel   = (wr_ptr == '0) ? dst_id : dst_q;
  assign last_word = (state == ST_DRAIN) && (pkt_len_t'(rd_ptr) == len_q - pkt_len_t'(1));
  // Read one word ahead on a drain handshake so the next word is ready back-to-back.
  assign rd_addr   = (state == ST_DRAIN && out_hs) ? rd_ptr + AW'(1) : rd_ptr;

  noc_pkt_buf #(.DEPTH(DEPTH), .AW(AW), .WIDTH(36)) u_buf (
    .clk     (clk_line),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data ({stream_in.tkeep, stream_in.tdata}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Packet FSM, pointers, latched header and overflow pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_line) begin
    if (clk_line_rst_high) begin
      state        <= ST_FILL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      len_q        <= '0;
      dst_q        <= '0;
      hdr_q        <= '0;
      pkt_overflow <= 1'b0;
    end else begin
      pkt_overflow <= 1'b0;
      case (state)
        ST_FILL: begin
          if (in_hs) begin
            if (wr_ptr == '0) dst_q <= dst_id;
            if (stream_in.tlast) begin
              len_q <= fill_len;
              hdr_q <= make_hdr(dst_sel, HsrcId, fill_len);
              state <= ST_HDR;
            end else if (wr_ptr == AW'(DEPTH - 1)) begin
              pkt_overflow <= 1'b1;
              state        <= ST_DROP;
            end
            wr_ptr <= wr_ptr + AW'(1);
          end
        end
        ST_DROP: begin
          if (in_hs && stream_in.tlast) begin
            len_q <= pkt_len_t'(DEPTH);
            hdr_q <= make_hdr(dst_q, HsrcId, pkt_len_t'(DEPTH));
            state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (out_hs) begin
            rd_ptr <= '0;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_hs) begin
            if (last_word) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              state  <= ST_FILL;
            end else begin
              rd_ptr <= rd_ptr + AW'(1);
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Decode stream outputs purely from registered state so nothing depends on TREADY.
  // NOTE: every output gets a default first, so no path through the case can infer a latch.
  always_comb begin
    stream_in.tready  = 1'b0;
    stream_out.tvalid = 1'b0;
    stream_out.tdata  = '0;
    stream_out.tkeep  = '0;
    stream_out.tlast  = 1'b0;
    case (state)
      ST_FILL, ST_DROP: stream_in.tready = 1'b1;
      ST_HDR: begin
        stream_out.tvalid = 1'b1;
        stream_out.tdata  = hdr_q;
        stream_out.tkeep  = 4'hF;
      end
      ST_DRAIN: begin
        stream_out.tvalid = 1'b1;
        stream_out.tdata  = rd_data[31:0];
        stream_out.tkeep  = rd_data[35:32];
        stream_out.tlast  = last_word;
      end
      default: ;
    endcase
  end

endmodule
